// File: rtl/w_pair_pkg.sv
// Shared types and constants for the equal-pair run generator and detector.
package w_pair_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    BREAK = 2'd2
  } state_t;

  localparam logic BRK_W1 = 1'b0;
  localparam logic BRK_W2 = 1'b1;

  localparam int DEF_REQ_RUN = 4;

endpackage

// File: rtl/w_pair_run_cnt.sv
// Emit index counter plus a modulo-REQ_RUN run counter; reports the last
// emit cycle of a command and the cycles that complete a full run.
module w_pair_run_cnt import w_pair_pkg::*; #(
  parameter int LEN_W   = 4,
  parameter int REQ_RUN = DEF_REQ_RUN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic [LEN_W-1:0] len,
  output logic             odd,
  output logic             last,
  output logic             hit
);

  localparam int MOD_W = (REQ_RUN > 1) ? $clog2(REQ_RUN) : 1;
  localparam logic [MOD_W-1:0] MOD_TOP = MOD_W'(REQ_RUN - 1);

  logic [LEN_W-1:0] idx;
  logic [MOD_W-1:0] mod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      mod <= '0;
    end else if (clear) begin
      idx <= '0;
      mod <= '0;
    end else if (step) begin
      idx <= idx + 1'b1;
      mod <= (mod == MOD_TOP) ? '0 : mod + 1'b1;
    end
  end

  // len is never zero while stepping, so len-1 cannot underflow in use
  assign odd  = idx[0];
  assign last = (idx == len - 1'b1);
  assign hit  = (mod == MOD_TOP);

endmodule

// File: rtl/w_pair_run_gen.sv
// Equal-pair run stimulus generator with exp_z hit prediction.
// Optional hit_cnt/run_ovf outputs when W_PAIR_HIT_COUNT_EN is defined.
module w_pair_run_gen import w_pair_pkg::*; #(
  parameter int LEN_W   = 4,
  parameter int REQ_RUN = DEF_REQ_RUN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_eq,
  input  logic             cmd_lvl,
  input  logic             cmd_alt,
  output logic             w1,
  output logic             w2,
  output logic             busy,
  output logic             done,
  output logic             exp_z
`ifdef W_PAIR_HIT_COUNT_EN
  ,
  output logic [7:0]       hit_cnt,
  output logic             run_ovf
`endif
);

  state_t state, next_state;

  logic [LEN_W-1:0] len_q;
  logic             eq_q, lvl_q, alt_q;
  logic             accept;
  logic             odd, last, hit;
  logic             emit_w1;

  assign accept = cmd_valid && (state == IDLE);

  w_pair_run_cnt #(
    .LEN_W   (LEN_W),
    .REQ_RUN (REQ_RUN)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .step  (state == EMIT),
    .len   (len_q),
    .odd   (odd),
    .last  (last),
    .hit   (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0;
      eq_q  <= 1'b0;
      lvl_q <= 1'b0;
      alt_q <= 1'b0;
    end else if (accept) begin
      len_q <= cmd_len;
      eq_q  <= cmd_eq;
      lvl_q <= cmd_lvl;
      alt_q <= cmd_alt;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (cmd_len == '0) ? BREAK : EMIT;
      EMIT:    if (last) next_state = BREAK;
      BREAK:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // IDLE and BREAK both park the pair at the mismatch value
  always_comb begin
    emit_w1   = lvl_q ^ (alt_q & odd);
    w1        = BRK_W1;
    w2        = BRK_W2;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    exp_z     = 1'b0;
    case (state)
      IDLE: cmd_ready = 1'b1;
      EMIT: begin
        busy  = 1'b1;
        w1    = emit_w1;
        w2    = eq_q ? emit_w1 : ~emit_w1;
        exp_z = eq_q & hit;
      end
      BREAK: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef W_PAIR_HIT_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt <= 8'd0;
      run_ovf <= 1'b0;
    end else begin
      if (exp_z && (hit_cnt != 8'hFF)) hit_cnt <= hit_cnt + 8'd1;
      if (accept && cmd_eq && ((cmd_len % REQ_RUN) != 0)) run_ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_w_pair_run_gen.sv
// Self-checking bench for w_pair_run_gen: queue-based reference model,
// directed literal checks and randomized commands.
module tb_w_pair_run_gen;

  localparam int LEN_W   = 4;
  localparam int REQ_RUN = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_eq = 1'b0, cmd_lvl = 1'b0, cmd_alt = 1'b0;
  logic             w1, w2, busy, done, exp_z;
`ifdef W_PAIR_HIT_COUNT_EN
  logic [7:0]       hit_cnt;
  logic             run_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  w_pair_run_gen #(.LEN_W(LEN_W), .REQ_RUN(REQ_RUN)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_eq    (cmd_eq),
    .cmd_lvl   (cmd_lvl),
    .cmd_alt   (cmd_alt),
    .w1        (w1),
    .w2        (w2),
    .busy      (busy),
    .done      (done),
    .exp_z     (exp_z)
`ifdef W_PAIR_HIT_COUNT_EN
    ,
    .hit_cnt   (hit_cnt),
    .run_ovf   (run_ovf)
`endif
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: each accepted command becomes a list of future cycles
  typedef struct packed {
    logic w1;
    logic w2;
    logic ez;
    logic dn;
  } ent_t;

  ent_t q[$];
  ent_t ent;
  int   m_hits = 0;
  bit   m_ovf  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_hits = 0;
      m_ovf  = 1'b0;
    end else if (q.size() != 0) begin
      if (q[0].ez && m_hits < 255) m_hits++;
      void'(q.pop_front());
    end else if (cmd_valid) begin
      for (int k = 0; k < int'(cmd_len); k++) begin
        ent.w1 = ((int'(cmd_lvl) + int'(cmd_alt) * k) % 2) != 0;
        ent.w2 = cmd_eq ? ent.w1 : !ent.w1;
        ent.ez = cmd_eq && ((k % REQ_RUN) == REQ_RUN - 1);
        ent.dn = 1'b0;
        q.push_back(ent);
      end
      ent = '{w1: 1'b0, w2: 1'b1, ez: 1'b0, dn: 1'b1};
      q.push_back(ent);
      if (cmd_eq && (int'(cmd_len) % REQ_RUN) != 0) m_ovf = 1'b1;
    end
  end

  always @(negedge clk) begin
    ent_t want;
    if (!rst) begin
      if (q.size() != 0) want = q[0];
      else               want = '{w1: 1'b0, w2: 1'b1, ez: 1'b0, dn: 1'b0};
      checkOutput("cycle", 16'({w1, w2, exp_z, done, busy, cmd_ready}),
                  16'({want.w1, want.w2, want.ez, want.dn, q.size() != 0, q.size() == 0}));
`ifdef W_PAIR_HIT_COUNT_EN
      checkOutput("hit_cnt", 16'(hit_cnt), 16'(m_hits));
      checkOutput("run_ovf", 16'(run_ovf), 16'(m_ovf));
`endif
    end
  end

  task automatic applyStimulus(input logic [LEN_W-1:0] len, input logic eq,
                               input logic lvl, input logic alt);
    int n = 0;
    cmd_len   = len;
    cmd_eq    = eq;
    cmd_lvl   = lvl;
    cmd_alt   = alt;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("accept_timeout", 16'(cmd_ready), 16'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_len = LEN_W'($urandom);
    cmd_eq  = 1'($urandom);
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("idle_timeout", 16'(cmd_ready), 16'd1);
  endtask

  task automatic resetPulse();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] zpat;
    logic [4:0] apat;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Quiet idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("idle", 16'({w1, w2, cmd_ready, busy, exp_z, done}), 16'b011000);
    end

    // len=8 equal held high: hits on emit cycles 4 and 8
    zpat = 8'b1000_1000;
    applyStimulus(4'd8, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("len8_emit", 16'({w1, w2, exp_z, done}), 16'({1'b1, 1'b1, zpat[k], 1'b0}));
    end
    @(negedge clk);
    checkOutput("len8_break", 16'({w1, w2, exp_z, done, busy}), 16'b01011);
    @(negedge clk);
    checkOutput("len8_ready", 16'({cmd_ready, busy}), 16'b10);

    // len=5 unequal alternating from 0
    apat = 5'b01010;
    applyStimulus(4'd5, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("len5_emit", 16'({w1, w2, exp_z, done}), 16'({apat[k], ~apat[k], 1'b0, 1'b0}));
    end
    @(negedge clk);
    checkOutput("len5_break", 16'({w1, w2, exp_z, done}), 16'b0101);
    waitIdle();

    // len=0 goes straight to the break cycle
    applyStimulus(4'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("len0_break", 16'({busy, done, w1, w2}), 16'b1101);
    @(negedge clk);
    checkOutput("len0_idle", 16'({busy, cmd_ready, done}), 16'b010);

    // Reset in the middle of a len=10 run
    applyStimulus(4'd10, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("rst_mid", 16'({w1, w2, cmd_ready, busy, exp_z, done}), 16'b011000);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(4'd3, 1'b1, 1'b1, 1'b1);
    waitIdle();

`ifdef W_PAIR_HIT_COUNT_EN
    resetPulse();
    @(negedge clk);
    checkOutput("cnt_clear", 16'({hit_cnt, run_ovf}), 16'd0);
    applyStimulus(4'd12, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'd6, 1'b1, 1'b1, 1'b0);
    waitIdle();
    @(negedge clk);
    checkOutput("hit_cnt_lit", 16'(hit_cnt), 16'd4);
    checkOutput("run_ovf_lit", 16'(run_ovf), 16'd1);
`endif

    // Randomized commands, sometimes back to back, sometimes with gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      applyStimulus(LEN_W'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    waitIdle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
